// File: rtl/cordic_vectoring.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cordic_vectoring: iterative vectoring CORDIC, I/Q -> magnitude and phase |
// | Optional macro CORDIC_GAIN_COMP_EN adds a shift-add gain stage (x*0.6073).|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cordic_vectoring #(
  parameter int IW      = 13,
  parameter int WW      = 18,
  parameter int OW      = 14,
  parameter int PW      = 20,
  parameter int NSTAGES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic signed [IW-1:0] i_xval,
  input  logic signed [IW-1:0] i_yval,
  output logic                 o_valid,
  output logic [OW-1:0]        o_mag,
  output logic [PW-1:0]        o_phase
);

  localparam int c_cnt_w  = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
  localparam int c_frac_w = WW - IW - 2;
  localparam int c_shift  = WW - OW;
  localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(NSTAGES - 1);
  localparam logic [PW-1:0]      c_half     = {1'b1, {(PW-1){1'b0}}};
  localparam logic [WW:0]        c_round    = (WW+1)'(1) << (c_shift - 1);
  localparam logic [WW:0]        c_mag_max  = (WW+1)'((1 << OW) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_GAIN = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_iter;
  logic signed [WW-1:0]  r_x, r_y;
  logic [PW-1:0]         r_ph;
  logic                  r_zero;
  logic                  r_ready;
  logic                  r_valid;
  logic [OW-1:0]         r_mag;
  logic [PW-1:0]         r_phase;

  // atan(2^-i) scaled so that 2^32 is a full turn
  function automatic logic [PW-1:0] atan_entry(input logic [c_cnt_w-1:0] idx);
    logic [31:0] a;
    case (int'(idx))
      0:  a = 32'h2000_0000;
      1:  a = 32'h12e4_051d;
      2:  a = 32'h09fb_385b;
      3:  a = 32'h0511_11d4;
      4:  a = 32'h028b_0d43;
      5:  a = 32'h0145_d7e1;
      6:  a = 32'h00a2_f61e;
      7:  a = 32'h0051_7c55;
      8:  a = 32'h0028_be53;
      9:  a = 32'h0014_5f2e;
      10: a = 32'h000a_2f98;
      11: a = 32'h0005_17cc;
      12: a = 32'h0002_8be6;
      13: a = 32'h0001_45f3;
      14: a = 32'h0000_a2f9;
      15: a = 32'h0000_517c;
      default: a = 32'd683565275 >> idx;
    endcase
    atan_entry = PW'(a >> (32 - PW));
  endfunction

  logic signed [WW-1:0] w_ex_x, w_ex_y, w_x0, w_y0;
  logic [PW-1:0]        w_ph0;
  assign w_ex_x = {{2{i_xval[IW-1]}}, i_xval, {c_frac_w{1'b0}}};
  assign w_ex_y = {{2{i_yval[IW-1]}}, i_yval, {c_frac_w{1'b0}}};
  // Left half-plane: rotate by 180 deg so the iterations only cover +-90 deg
  assign w_x0  = w_ex_x[WW-1] ? -w_ex_x : w_ex_x;
  assign w_y0  = w_ex_x[WW-1] ? -w_ex_y : w_ex_y;
  assign w_ph0 = w_ex_x[WW-1] ? c_half : '0;

  logic signed [WW-1:0] w_xs, w_ys, w_x_next, w_y_next;
  logic [PW-1:0]        w_angle, w_ph_next;
  assign w_xs    = r_x >>> r_iter;
  assign w_ys    = r_y >>> r_iter;
  assign w_angle = atan_entry(r_iter);

  always_comb begin
    w_x_next  = r_x;
    w_y_next  = r_y;
    w_ph_next = r_ph;
    if (!r_y[WW-1]) begin
      w_x_next  = r_x + w_ys;
      w_y_next  = r_y - w_xs;
      w_ph_next = r_ph + w_angle;
    end else begin
      w_x_next  = r_x - w_ys;
      w_y_next  = r_y + w_xs;
      w_ph_next = r_ph - w_angle;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [WW-1:0] w_x_gain;
  assign w_x_gain = (r_x >>> 1) + (r_x >>> 3) - (r_x >>> 6) - (r_x >>> 9) - (r_x >>> 13);
`endif

  // Round half-up, clamp a (theoretically impossible) negative x to zero
  logic [WW:0]   w_round, w_shifted;
  logic [OW-1:0] w_mag;
  assign w_round   = r_x[WW-1] ? c_round : ({1'b0, r_x} + c_round);
  assign w_shifted = w_round >> c_shift;
  assign w_mag     = (w_shifted > c_mag_max) ? {OW{1'b1}} : w_shifted[OW-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_ph    <= '0;
      r_zero  <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_mag   <= '0;
      r_phase <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_ph    <= w_ph0;
            r_zero  <= (i_xval == '0) && (i_yval == '0);
            r_iter  <= '0;
            r_ready <= 1'b0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_x    <= w_x_next;
          r_y    <= w_y_next;
          r_ph   <= w_ph_next;
          r_iter <= r_iter + 1'b1;
          if (r_iter == c_last) begin
            r_iter  <= '0;
`ifdef CORDIC_GAIN_COMP_EN
            r_state <= S_GAIN;
`else
            r_state <= S_OUT;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_GAIN: begin
          r_x     <= w_x_gain;
          r_state <= S_OUT;
        end
`endif
        S_OUT: begin
          r_valid <= 1'b1;
          r_mag   <= r_zero ? '0 : w_mag;
          r_phase <= r_zero ? '0 : r_ph;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_mag   = r_mag;
  assign o_phase = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cordic_vectoring: directed self-checking bench for cordic_vectoring   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cordic_vectoring;

  localparam int IW = 13, WW = 18, OW = 14, PW = 20, NSTAGES = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int c_lat   = NSTAGES + 2;
  localparam int c_m1000 = 500;
  localparam int c_mbig  = 2897;
`else
  localparam int c_lat   = NSTAGES + 1;
  localparam int c_m1000 = 823;
  localparam int c_mbig  = 4770;
`endif
  localparam int c_period = c_lat + 1;
  // One y LSB against |x|~13000 is ~12 phase units, so the phase bound is 16
  localparam int c_ptol = 16;

  logic                 i_clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic signed [IW-1:0] i_xval = '0;
  logic signed [IW-1:0] i_yval = '0;
  logic                 o_valid;
  logic [OW-1:0]        o_mag;
  logic [PW-1:0]        o_phase;

  int n_chk = 0;
  int n_pass = 0;

  cordic_vectoring #(.IW(IW), .WW(WW), .OW(OW), .PW(PW), .NSTAGES(NSTAGES)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_xval  (i_xval),
    .i_yval  (i_yval),
    .o_valid (o_valid),
    .o_mag   (o_mag),
    .o_phase (o_phase)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol, input bit wrap);
    int d;
    bit ok;
    d = obs - exp;
    if (wrap) begin
      d = d & ((1 << PW) - 1);
      if (d >= (1 << (PW - 1))) d = d - (1 << PW);
    end
    ok = (d <= tol) && (d >= -tol);
    n_chk++;
    assert (ok === 1'b1) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h+-%0d", tag, obs, exp, tol);
  endtask

  // Offer one sample, then report the result, latency and handshake state
  task automatic run_sample(input int x, input int y, output int mag, output int ph,
                            output int lat, output int rdy, output int pulse_low);
    int guard;
    guard = 0;
    mag = -1; ph = -1; lat = -1; rdy = -1; pulse_low = -1;
    while (o_ready !== 1'b1 && guard < 50) begin
      @(posedge i_clk); #1;
      guard++;
    end
    i_valid = 1'b1;
    i_xval  = x[IW-1:0];
    i_yval  = y[IW-1:0];
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge i_clk); #1;
      if (o_valid === 1'b1) begin
        lat = c;
        mag = int'(o_mag);
        ph  = int'(o_phase);
        rdy = int'(o_ready);
        break;
      end
    end
    @(posedge i_clk); #1;
    pulse_low = (o_valid === 1'b0) ? 1 : 0;
  endtask

  task automatic sample_case(input string tag, input int x, input int y,
                             input int exp_mag, input int mtol, input int exp_ph);
    int mag, ph, lat, rdy, pl;
    run_sample(x, y, mag, ph, lat, rdy, pl);
    chk_eq({tag, "_latency"}, lat, c_lat);
    chk_tol({tag, "_mag"}, mag, exp_mag, mtol, 1'b0);
    chk_tol({tag, "_phase"}, ph, exp_ph, c_ptol, 1'b1);
    chk_eq({tag, "_ready_with_valid"}, rdy, 1);
    chk_eq({tag, "_single_pulse"}, pl, 1);
  endtask

  initial begin
    int ax[4];
    int ay[4];
    int aph[4];
    int rdy_bad, val_bad, nval, spur;
    int mag, ph, lat, rdy, pl;
    ax  = '{1000, 0, -1000, 0};
    ay  = '{0, 1000, 0, -1000};
    aph = '{'h00000, 'h40000, 'h80000, 'hC0000};

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk_eq("reset_valid", int'(o_valid), 0);
    chk_eq("reset_mag", int'(o_mag), 0);
    chk_eq("reset_phase", int'(o_phase), 0);
    chk_eq("reset_ready", int'(o_ready), 1);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // Axis and diagonal vectors
    sample_case("pos_x", 1000, 0, c_m1000, 1, 'h00000);
    sample_case("pos_y", 0, 1000, c_m1000, 1, 'h40000);
    sample_case("neg_y", 0, -1000, c_m1000, 1, 'hC0000);
    sample_case("neg_x", -1000, 0, c_m1000, 1, 'h80000);
    sample_case("most_neg", -4096, -4096, c_mbig, 2, 'hA0000);

    // Zero vector is forced to exactly zero
    run_sample(0, 0, mag, ph, lat, rdy, pl);
    chk_eq("zero_latency", lat, c_lat);
    chk_eq("zero_mag", mag, 0);
    chk_eq("zero_phase", ph, 0);

    // i_valid held high with a fresh sample every cycle
    rdy_bad = 0; val_bad = 0; nval = 0;
    for (int k = 0; k <= 5 * c_period; k++) begin
      i_valid = (k <= 4 * c_period);
      i_xval  = ax[k % 4][IW-1:0];
      i_yval  = ay[k % 4][IW-1:0];
      if (o_ready !== ((k % c_period) == 0)) rdy_bad++;
      if (o_valid !== (k > 0 && (k % c_period) == 0)) val_bad++;
      if (o_valid === 1'b1 && k >= c_period) begin
        nval++;
        chk_tol("stream_phase", int'(o_phase), aph[(k - c_period) % 4], c_ptol, 1'b1);
        chk_tol("stream_mag", int'(o_mag), c_m1000, 1, 1'b0);
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    chk_eq("stream_ready_pattern_errors", rdy_bad, 0);
    chk_eq("stream_valid_pattern_errors", val_bad, 0);
    chk_eq("stream_valid_count", nval, 5);

    // Reset while the counter is at iteration 5
    i_xval = 13'sd1000; i_yval = '0; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    chk_eq("abort_valid", int'(o_valid), 0);
    chk_eq("abort_mag", int'(o_mag), 0);
    chk_eq("abort_phase", int'(o_phase), 0);
    chk_eq("abort_ready", int'(o_ready), 1);
    spur = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge i_clk); #1;
      if (o_valid !== 1'b0) spur++;
    end
    chk_eq("abort_no_valid", spur, 0);
    sample_case("after_abort", 1000, 0, c_m1000, 1, 'h00000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
